// File: rtl/repair_solution_buffer.sv
// Repair solution buffer: collects BIRA solution words, releases them to the fuse
// programmer only on a repairable verdict. Optional SOL_DEDUP_EN drops duplicate words.
module repair_solution_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SOL_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sol_valid,
    input  logic [SOL_W-1:0]             solution,
    input  logic                         verdict_valid,
    input  logic                         repair,
    input  logic                         early_term,
    input  logic                         clr,
    output logic                         fuse_valid,
    output logic [SOL_W-1:0]             fuse_word,
    input  logic                         fuse_ready,
    output logic                         done,
    output logic                         fail,
    output logic [$clog2(DEPTH+1)-1:0]   sol_count,
    output logic                         overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_FAIL    = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic [SOL_W-1:0] mem_q [DEPTH];
    logic [SOL_W-1:0] mem_d [DEPTH];

    logic dup_c;
    logic pop_c;

`ifdef SOL_DEDUP_EN
    // Parallel match of the incoming word against every occupied slot
    always_comb begin : dedup_match
        logic [PTR_W-1:0] off;
        dup_c = 1'b0;
        off   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (mem_q[i] == solution)) begin
                dup_c = 1'b1;
            end
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    assign fuse_valid = (state_q == S_DRAIN) && (count_q != '0);
    assign fuse_word  = fuse_valid ? mem_q[rd_ptr_q] : '0;
    assign pop_c      = fuse_valid && fuse_ready;
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);
    assign sol_count  = count_q;
    assign overflow   = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        case (state_q)
            S_COLLECT: begin
                // Push lands before the verdict so a same-cycle overflow still fails the die
                if (sol_valid && !dup_c) begin
                    if (count_q == CNT_W'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_d[wr_ptr_q] = solution;
                        wr_ptr_d        = wr_ptr_q + 1'b1;
                        count_d         = count_q + 1'b1;
                    end
                end
                if (early_term) begin
                    state_d = S_FAIL;
                end else if (verdict_valid) begin
                    state_d = (repair && !overflow_d) ? S_DRAIN : S_FAIL;
                end
            end
            S_DRAIN: begin
                if (pop_c) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                if ((count_q == '0) || (pop_c && (count_q == CNT_W'(1)))) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        // An unrepairable die never keeps any words
        if (state_d == S_FAIL) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        if (clr) begin
            state_d    = S_COLLECT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COLLECT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_repair_solution_buffer.sv
// Directed bench for repair_solution_buffer; follows SOL_DEDUP_EN for the duplicate case.
module tb_repair_solution_buffer;

    logic        clk;
    logic        rst;
    logic        sol_valid;
    logic [15:0] solution;
    logic        verdict_valid;
    logic        repair;
    logic        early_term;
    logic        clr;
    logic        fuse_valid;
    logic [15:0] fuse_word;
    logic        fuse_ready;
    logic        done;
    logic        fail;
    logic [3:0]  sol_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    repair_solution_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .sol_valid     (sol_valid),
        .solution      (solution),
        .verdict_valid (verdict_valid),
        .repair        (repair),
        .early_term    (early_term),
        .clr           (clr),
        .fuse_valid    (fuse_valid),
        .fuse_word     (fuse_word),
        .fuse_ready    (fuse_ready),
        .done          (done),
        .fail          (fail),
        .sol_count     (sol_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        sol_valid = 1'b1;
        solution  = w;
        step();
        sol_valid = 1'b0;
    endtask

    task automatic verdict(input logic r);
        verdict_valid = 1'b1;
        repair        = r;
        step();
        verdict_valid = 1'b0;
        repair        = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int pat [7];
        int idx;
        int hs;
        logic [15:0] exp_w [8];
        int exp_n;

        rst = 1'b1; sol_valid = 0; solution = '0; verdict_valid = 0; repair = 0;
        early_term = 0; clr = 0; fuse_ready = 0;
        step(); step();
        rst = 1'b0;

        // reset values
        chk("rst_fv", 32'(fuse_valid), 32'd0);
        chk("rst_fw", 32'(fuse_word), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_cnt", 32'(sol_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // basic three-word drain
        push(16'h2405); push(16'h3812); push(16'h0003);
        chk("t1_cnt", 32'(sol_count), 32'd3);
        fuse_ready = 1'b1;
        verdict(1'b1);
        chk("t1_fv0", 32'(fuse_valid), 32'd1);
        chk("t1_w0", 32'(fuse_word), 32'h2405);
        step();
        chk("t1_w1", 32'(fuse_word), 32'h3812);
        step();
        chk("t1_w2", 32'(fuse_word), 32'h0003);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cnt0", 32'(sol_count), 32'd0);
        chk("t1_fvoff", 32'(fuse_valid), 32'd0);
        chk("t1_nofail", 32'(fail), 32'd0);
        push(16'h7777);
        chk("t1_ignore", 32'(sol_count), 32'd0);
        pulse_clr();
        chk("t1_clr_done", 32'(done), 32'd0);

        // overflow on ninth word
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
        chk("t2_full", 32'(sol_count), 32'd8);
        chk("t2_noovf", 32'(overflow), 32'd0);
        push(16'h1008);
        chk("t2_cnt8", 32'(sol_count), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd1);
        verdict(1'b1);
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_fv", 32'(fuse_valid), 32'd0);
        chk("t2_flush", 32'(sol_count), 32'd0);
        chk("t2_nodone", 32'(done), 32'd0);
        step();
        chk("t2_fv_later", 32'(fuse_valid), 32'd0);
        pulse_clr();
        chk("t2_clr_ovf", 32'(overflow), 32'd0);
        chk("t2_clr_fail", 32'(fail), 32'd0);

        // early_term beats a repairable verdict
        push(16'h0101); push(16'h0202);
        early_term = 1'b1;
        verdict(1'b1);
        early_term = 1'b0;
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_fv", 32'(fuse_valid), 32'd0);
        step();
        chk("t3_fv_later", 32'(fuse_valid), 32'd0);
        chk("t3_nodone", 32'(done), 32'd0);
        pulse_clr();

        // verdict repair=0
        push(16'h0303);
        verdict(1'b0);
        chk("t3b_fail", 32'(fail), 32'd1);
        pulse_clr();

        // backpressure with stalls
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i));
        fuse_ready = 1'b0;
        verdict(1'b1);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        idx = 0;
        hs  = 0;
        for (int k = 0; k < 7; k++) begin
            fuse_ready = pat[k][0];
            chk($sformatf("t4_fv%0d", k), 32'(fuse_valid), 32'd1);
            chk($sformatf("t4_w%0d", k), 32'(fuse_word), 32'hA000 + 32'(idx));
            if (fuse_valid && fuse_ready) hs++;
            step();
            if (pat[k] != 0) idx++;
        end
        fuse_ready = 1'b0;
        chk("t4_hs", 32'(hs), 32'd4);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_cnt", 32'(sol_count), 32'd0);
        pulse_clr();

        // clr mid-drain, then a fresh single-word die
        for (int i = 0; i < 5; i++) push(16'hB000 + 16'(i));
        fuse_ready = 1'b1;
        verdict(1'b1);
        chk("t5_w0", 32'(fuse_word), 32'hB000);
        step();
        chk("t5_w1", 32'(fuse_word), 32'hB001);
        step();
        chk("t5_cnt3", 32'(sol_count), 32'd3);
        pulse_clr();
        chk("t5_clr_cnt", 32'(sol_count), 32'd0);
        chk("t5_clr_fv", 32'(fuse_valid), 32'd0);
        chk("t5_clr_done", 32'(done), 32'd0);
        push(16'h1111);
        verdict(1'b1);
        chk("t5_fv", 32'(fuse_valid), 32'd1);
        chk("t5_w", 32'(fuse_word), 32'h1111);
        step();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_fvoff", 32'(fuse_valid), 32'd0);
        pulse_clr();

        // empty drain goes straight to done
        verdict(1'b1);
        chk("t6_fv", 32'(fuse_valid), 32'd0);
        chk("t6_notyet", 32'(done), 32'd0);
        step();
        chk("t6_done", 32'(done), 32'd1);
        pulse_clr();

        // push and verdict in the same cycle fills to 8; full-rate drain
        for (int i = 0; i < 7; i++) push(16'hC000 + 16'(i));
        sol_valid = 1'b1; solution = 16'hC007;
        verdict(1'b1);
        sol_valid = 1'b0;
        chk("t7_cnt8", 32'(sol_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t7_w%0d", i), 32'(fuse_word), 32'hC000 + 32'(i));
            step();
        end
        chk("t7_done", 32'(done), 32'd1);
        pulse_clr();

        // same-cycle ninth push overflows and fails the verdict
        for (int i = 0; i < 8; i++) push(16'hD000 + 16'(i));
        sol_valid = 1'b1; solution = 16'hD008;
        verdict(1'b1);
        sol_valid = 1'b0;
        chk("t8_fail", 32'(fail), 32'd1);
        chk("t8_ovf", 32'(overflow), 32'd1);
        pulse_clr();

        // duplicate handling
        push(16'h2405); push(16'h2405); push(16'h2406);
`ifdef SOL_DEDUP_EN
        exp_n = 2;
        exp_w[0] = 16'h2405; exp_w[1] = 16'h2406;
`else
        exp_n = 3;
        exp_w[0] = 16'h2405; exp_w[1] = 16'h2405; exp_w[2] = 16'h2406;
`endif
        chk("t9_cnt", 32'(sol_count), 32'(exp_n));
        verdict(1'b1);
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("t9_w%0d", i), 32'(fuse_word), 32'(exp_w[i]));
            step();
        end
        chk("t9_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
